// File: rtl/cap_pkg.sv
// Shared types and helpers for the camera capture front end.
package cap_pkg;

    // Capture sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_CAP  = 2'd2,
        ST_DONE = 2'd3
    } cap_state_e;

    // Geometry held in the config registers until the first capture loads real values.
    localparam int DEF_SCALE  = 1;
    localparam int DEF_ROI_X0 = 0;
    localparam int DEF_ROI_Y0 = 0;
    localparam int DEF_ROI_W  = 640;
    localparam int DEF_ROI_H  = 480;

    // A decimation factor of 0 means "no decimation", the same as 1.
    function automatic logic [2:0] norm_scale(input logic [2:0] s);
        return (s == 3'd0) ? 3'd1 : s;
    endfunction

endpackage

// File: rtl/cap_decim_cnt.sv
// Decimation phase counter plus decimated coordinate counter for one axis.
// phase cycles 0..scale-1 on each advance; coord steps when phase wraps.
// clr has priority over adv and returns both to zero.
module cap_decim_cnt
    import cap_pkg::*;
#(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          adv,
    input  logic [2:0]    scale,
    output logic [2:0]    phase,
    output logic [CW-1:0] coord
);

    // Phase/coordinate update; the >= guards against a phase left above a newly smaller scale.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase <= 3'd0;
            coord <= '0;
        end else if (clr) begin
            phase <= 3'd0;
            coord <= '0;
        end else if (adv) begin
            if (phase >= scale - 3'd1) begin
                phase <= 3'd0;
                coord <= coord + CW'(1);
            end else begin
                phase <= phase + 3'd1;
            end
        end
    end

endmodule

// File: rtl/cam_capture_roi.sv
// DVP luma capture: 2-stage input pipe, decimation, ROI crop and ping-pong
// frame-buffer writes through an active-low-enable SRAM port.
// Write port contract: a word is written in every cycle where cenb_frame_buf
// is low, with ab_frame_buf/db_frame_buf valid in that same cycle; there is no
// back-pressure, the frame store must accept one word per clock.
module cam_capture_roi
    import cap_pkg::*;
#(
    parameter int DW         = 8,
    parameter int W_PW       = 10,
    parameter int W_PH       = 9,
    parameter int LINE_PITCH = 512,
    parameter int BUF_WORDS  = 131072,
    parameter int AW         = 18
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [2:0]    cam_scale,
    input  logic [W_PW:0] roi_x0,
    input  logic [W_PW:0] roi_w,
    input  logic [W_PH:0] roi_y0,
    input  logic [W_PH:0] roi_h,
    input  logic          cont_mode,
    input  logic          capture_go,
    input  logic          buf_release,
    input  logic          cam_vsync_i,
    input  logic          cam_href_i,
    input  logic [DW-1:0] cam_data_i,
    output logic          capture_ready,
    output logic          ready_idx,
    output logic          busy,
    output logic          frame_drop,
    output logic [AW-1:0] ab_frame_buf,
    output logic          cenb_frame_buf,
    output logic [DW-1:0] db_frame_buf,
    output logic [1:0]    dbg_state
);

    localparam int XW = W_PW + 1;
    localparam int YW = W_PH + 1;

    logic          vs1, vs2, hr1, hr2;
    logic [DW-1:0] d1, d2;
    logic          vsync_fall, vsync_rise, href_e1, href_e2, href_fall;

    cap_state_e    state, state_n;
    logic          cfg_load;
    logic          wr_idx;
    logic [1:0]    held, held_n, rel_mask, set_mask;
    logic          buf_free;

    logic [2:0]    cfg_scale;
    logic [XW-1:0] cfg_x0, cfg_w;
    logic [YW-1:0] cfg_y0, cfg_h;

    logic [2:0]    h_phase, v_phase;
    logic [XW-1:0] x, dx;
    logic [YW-1:0] y, dy;
    logic          in_x, in_y, pitch_ok, kept, wr;
    logic [AW-1:0] addr;

    // Input register pipe; stage 2 is the pixel being processed this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs1 <= 1'b0; vs2 <= 1'b0;
            hr1 <= 1'b0; hr2 <= 1'b0;
            d1  <= '0;   d2  <= '0;
        end else begin
            vs1 <= cam_vsync_i; vs2 <= vs1;
            hr1 <= cam_href_i;  hr2 <= hr1;
            d1  <= cam_data_i;  d2  <= d1;
        end
    end

    // Frame edges come from stage 1 vs stage 2; href during vsync blanking is masked out.
    assign vsync_fall = vs2 & ~vs1;
    assign vsync_rise = ~vs2 & vs1;
    assign href_e1    = hr1 & ~vs1;
    assign href_e2    = hr2 & ~vs2;
    assign href_fall  = href_e2 & ~href_e1;

    // Horizontal: runs while the line is valid, cleared between lines.
    cap_decim_cnt #(.CW(XW)) u_h_cnt (
        .clk(clk), .rstn(rstn), .clr(~href_e2), .adv(href_e2),
        .scale(cfg_scale), .phase(h_phase), .coord(x)
    );

    // Vertical: steps once per line end, cleared at frame end.
    cap_decim_cnt #(.CW(YW)) u_v_cnt (
        .clk(clk), .rstn(rstn), .clr(vsync_rise), .adv(href_fall),
        .scale(cfg_scale), .phase(v_phase), .coord(y)
    );

    assign buf_free = ~held[wr_idx];

    // Sequencer state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Sequencer next state and pulse outputs.
    always_comb begin
        state_n       = state;
        cfg_load      = 1'b0;
        frame_drop    = 1'b0;
        capture_ready = 1'b0;
        case (state)
            ST_IDLE: if (capture_go) state_n = ST_ARM;
            ST_ARM: begin
                if (vsync_fall) begin
                    if (buf_free) begin
                        state_n  = ST_CAP;
                        cfg_load = 1'b1;
                    end else begin
                        frame_drop = 1'b1;
                    end
                end
            end
            ST_CAP:  if (vsync_rise) state_n = ST_DONE;
            ST_DONE: begin
                capture_ready = 1'b1;
                state_n       = cont_mode ? ST_ARM : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Buffer hold tracking: a release frees the oldest held buffer as it was
    // before this cycle, so a coincident completion is never freed by it.
    always_comb begin
        rel_mask = 2'b00;
        if (buf_release) begin
            case (held)
                2'b01:   rel_mask = 2'b01;
                2'b10:   rel_mask = 2'b10;
                2'b11:   rel_mask = 2'b01 << wr_idx;
                default: rel_mask = 2'b00;
            endcase
        end
        set_mask = (state == ST_DONE) ? (2'b01 << wr_idx) : 2'b00;
        held_n   = (held & ~rel_mask) | set_mask;
    end

    // Buffer bookkeeping: hold set, write-buffer toggle, ready index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            held      <= 2'b00;
            wr_idx    <= 1'b0;
            ready_idx <= 1'b0;
        end else begin
            held <= held_n;
            if (state == ST_DONE) wr_idx <= ~wr_idx;
            if (state == ST_CAP && vsync_rise) ready_idx <= wr_idx;
        end
    end

    // Geometry snapshot taken when a frame is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_scale <= 3'(DEF_SCALE);
            cfg_x0    <= XW'(DEF_ROI_X0);
            cfg_w     <= XW'(DEF_ROI_W);
            cfg_y0    <= YW'(DEF_ROI_Y0);
            cfg_h     <= YW'(DEF_ROI_H);
        end else if (cfg_load) begin
            cfg_scale <= norm_scale(cam_scale);
            cfg_x0    <= roi_x0;
            cfg_w     <= roi_w;
            cfg_y0    <= roi_y0;
            cfg_h     <= roi_h;
        end
    end

    // Crop window test; sums are one bit wider so x0+w cannot wrap.
    always_comb begin
        in_x     = ({1'b0, x} >= {1'b0, cfg_x0}) &&
                   ({1'b0, x} <  ({1'b0, cfg_x0} + {1'b0, cfg_w}));
        in_y     = ({1'b0, y} >= {1'b0, cfg_y0}) &&
                   ({1'b0, y} <  ({1'b0, cfg_y0} + {1'b0, cfg_h}));
        dx       = x - cfg_x0;
        dy       = y - cfg_y0;
        pitch_ok = 32'(dx) < 32'(LINE_PITCH);
        kept     = (h_phase == 3'd0) && (v_phase == 3'd0);
        wr       = (state == ST_CAP) && href_e2 && kept && in_x && in_y && pitch_ok;
        addr     = (wr_idx ? AW'(BUF_WORDS) : AW'(0)) +
                   AW'(dy) * AW'(LINE_PITCH) + AW'(dx);
    end

    // Write port register: third clock after the sample entered the pipe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cenb_frame_buf <= 1'b1;
            ab_frame_buf   <= '0;
            db_frame_buf   <= '0;
        end else begin
            cenb_frame_buf <= ~wr;
            if (wr) begin
                ab_frame_buf <= addr;
                db_frame_buf <= d2;
            end
        end
    end

endmodule
